serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 117 +++++++++++
 tb/tb_serial_subtractor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first.
// Optional macro SERIAL_SUB_OVF_EN adds a signed-overflow output 'ovf'.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] acc_ext;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             d_bit;
  logic             br_bit;
  logic             last_bit;

  function automatic logic [1:0] sub_cell(input logic ai, input logic bi, input logic bri);
    logic [1:0] r;
    r[0] = ai ^ bi ^ bri;
    r[1] = (~ai & bi) | (~(ai ^ bi) & bri);
    return r;
  endfunction

  assign {br_bit, d_bit} = sub_cell(a_sh[0], b_sh[0], br);
  assign last_bit        = (cnt == LAST);
  // Completed result bits sit in acc; the newest bit enters at the MSB.
  assign acc_ext         = {d_bit, acc};
  assign busy            = (state == RUN);
  assign done            = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)    state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:                  state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // Control and visible result registers (reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      br   <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          br  <= bin;
          cnt <= '0;
        end
        RUN: begin
          br  <= br_bit;
          cnt <= cnt + CNT_W'(1);
          if (last_bit) begin
            diff <= acc_ext;
            bout <= br_bit;
`ifdef SERIAL_SUB_OVF_EN
            // On the final bit a_sh[0]/b_sh[0] are the operand sign bits.
            ovf  <= (a_sh[0] ^ b_sh[0]) & (d_bit ^ a_sh[0]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Operand and partial-result shift registers (no reset needed)
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        a_sh <= a;
        b_sh <= b;
      end
      RUN: begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        acc  <= acc_ext[WIDTH-1:1];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic reference model.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: {ovf, bout, diff} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int u, s;
    logic [W-1:0] dd;
    logic bo, ov;
    u  = int'(x) - int'(y) - int'(c);
    s  = int'($signed(x)) - int'($signed(y)) - int'(c);
    dd = W'(u);
    bo = (u < 0);
    ov = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
    return {ov, bo, dd};
  endfunction

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; a = 8'hA5; b = 8'h11; bin = 1'b1;
    step; step;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b diff=%h bout=%b, required 0 0 00 0", busy, done, diff, bout);
    end
`ifdef SERIAL_SUB_OVF_EN
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ovf: ovf=%b, required 0", ovf);
    end
`endif
    rst = 1'b0; start = 1'b0;
    step;
  endtask

  // One full operation; inputs are scrambled while running to prove they were captured.
  task automatic test_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input string name);
    logic [W+1:0] exp;
    logic [W-1:0] held;
    exp = model(ta, tb_, tc);
    held = diff;
    a = ta; b = tb_; bin = tc; start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0 || diff !== held) begin
        n_err++;
        $display("FAIL %s_run%0d: busy=%b done=%b diff=%h, required busy=1 done=0 diff=%h",
                 name, i + 1, busy, done, diff, held);
      end
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      step;
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || diff !== exp[W-1:0] || bout !== exp[W]) begin
      n_err++;
      $display("FAIL %s_result: done=%b busy=%b diff=%h bout=%b, required 1 0 %h %b",
               name, done, busy, diff, bout, exp[W-1:0], exp[W]);
    end
`ifdef SERIAL_SUB_OVF_EN
    n_cmp++;
    if (ovf !== exp[W+1]) begin
      n_err++;
      $display("FAIL %s_ovf: ovf=%b, required %b", name, ovf, exp[W+1]);
    end
`endif
    step;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== exp[W-1:0] || bout !== exp[W]) begin
      n_err++;
      $display("FAIL %s_hold: done=%b busy=%b diff=%h bout=%b, required 0 0 %h %b",
               name, done, busy, diff, bout, exp[W-1:0], exp[W]);
    end
  endtask

  task automatic test_directed;
    test_op(8'h0F, 8'h05, 1'b0, "sub_0f_05");
    test_op(8'h05, 8'h0F, 1'b0, "sub_05_0f");
    test_op(8'h00, 8'h00, 1'b1, "sub_borrow_in");
    test_op(8'h80, 8'h01, 1'b0, "sub_ovf");
    test_op(8'h7F, 8'h80, 1'b0, "sub_ovf_pos");
    test_op(8'hFF, 8'hFF, 1'b1, "sub_all_ones");
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++)
      test_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rand%0d", i));
  endtask

  task automatic test_start_ignored;
    int nd;
    logic [W-1:0] got;
    logic gbo;
    nd = 0; got = '0; gbo = 1'b0;
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    step;
    start = 1'b0;
    step; step;
    start = 1'b1; a = 8'hFF;
    step;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin nd++; got = diff; gbo = bout; end
      step;
    end
    n_cmp++;
    if (nd !== 1 || got !== 8'h22 || gbo !== 1'b0) begin
      n_err++;
      $display("FAIL start_ignored: dones=%0d diff=%h bout=%b, required 1 22 0", nd, got, gbo);
    end
  endtask

  task automatic test_reset_abort;
    int nd;
    nd = 0;
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    step;
    start = 1'b0;
    step; step; step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state: busy=%b done=%b diff=%h bout=%b, required 0 0 00 0", busy, done, diff, bout);
    end
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) nd++;
      step;
    end
    n_cmp++;
    if (nd !== 0) begin
      n_err++;
      $display("FAIL abort_no_done: dones=%0d, required 0", nd);
    end
    test_op(8'h10, 8'h01, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back;
    logic [W+1:0] exp;
    int nd, last, both;
    nd = 0; last = -1; both = 0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    exp = model(a, b, bin);
    start = 1'b1;
    for (int e = 0; e < 42; e++) begin
      step;
      if (busy === 1'b1 && done === 1'b1) both++;
      if (done === 1'b1) begin
        nd++;
        n_cmp++;
        if (diff !== exp[W-1:0] || bout !== exp[W] || e !== ((last < 0) ? 8 : last + 10)) begin
          n_err++;
          $display("FAIL b2b_done%0d: edge=%0d diff=%h bout=%b, required edge=%0d diff=%h bout=%b",
                   nd, e, diff, bout, (last < 0) ? 8 : last + 10, exp[W-1:0], exp[W]);
        end
        last = e;
      end
      if (e == 29) start = 1'b0;
    end
    n_cmp++;
    if (nd !== 3 || both !== 0) begin
      n_err++;
      $display("FAIL b2b_count: dones=%0d overlap=%0d, required 3 0", nd, both);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    test_reset;
    test_directed;
    test_random;
    test_start_ignored;
    test_reset_abort;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
